// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// rv_ctrl_pkg : shared encodings for the RV32I multicycle controller/datapath
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } op_class_t;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    localparam logic [2:0] c_imm_i    = 3'd0;
    localparam logic [2:0] c_imm_s    = 3'd1;
    localparam logic [2:0] c_imm_b    = 3'd2;
    localparam logic [2:0] c_imm_u    = 3'd3;
    localparam logic [2:0] c_imm_j    = 3'd4;
    localparam logic [2:0] c_imm_none = 3'd7;

    localparam logic [1:0] c_pc_plus4  = 2'd0;
    localparam logic [1:0] c_pc_target = 2'd1;
    localparam logic [1:0] c_pc_jalr   = 2'd2;

    localparam logic [1:0] c_wb_alu = 2'd0;
    localparam logic [1:0] c_wb_mem = 2'd1;
    localparam logic [1:0] c_wb_pc4 = 2'd2;

    localparam logic [1:0] c_alu_add    = 2'd0;
    localparam logic [1:0] c_alu_sub    = 2'd1;
    localparam logic [1:0] c_alu_funct  = 2'd2;
    localparam logic [1:0] c_alu_pass_b = 2'd3;

    localparam logic [1:0] c_cause_none    = 2'd0;
    localparam logic [1:0] c_cause_illegal = 2'd1;
    localparam logic [1:0] c_cause_timeout = 2'd2;

    // funct3 010/011 have no branch meaning in RV32I
    function automatic logic branch_legal(input logic [2:0] funct3);
        return (funct3 != 3'b010) && (funct3 != 3'b011);
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       eq,
                                          input logic       lt,
                                          input logic       ltu);
        logic cond;
        case (funct3[2:1])
            2'b00:   cond = eq;
            2'b10:   cond = lt;
            2'b11:   cond = ltu;
            default: cond = 1'b0;
        endcase
        return cond ^ funct3[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv_opcode_class.sv
// ============================================================================
// rv_opcode_class : combinational opcode -> class / immediate format / legal
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] imm_sel,
    output logic       legal
);

    always_comb begin
        op_class = CLS_R;
        imm_sel  = c_imm_none;
        legal    = 1'b1;
        case (opcode)
            c_op_r:      begin op_class = CLS_R;      imm_sel = c_imm_none; end
            c_op_i:      begin op_class = CLS_I;      imm_sel = c_imm_i;    end
            c_op_load:   begin op_class = CLS_LOAD;   imm_sel = c_imm_i;    end
            c_op_store:  begin op_class = CLS_STORE;  imm_sel = c_imm_s;    end
            c_op_branch: begin op_class = CLS_BRANCH; imm_sel = c_imm_b;    end
            c_op_lui:    begin op_class = CLS_LUI;    imm_sel = c_imm_u;    end
            c_op_auipc:  begin op_class = CLS_AUIPC;  imm_sel = c_imm_u;    end
            c_op_jal:    begin op_class = CLS_JAL;    imm_sel = c_imm_j;    end
            c_op_jalr:   begin op_class = CLS_JALR;   imm_sel = c_imm_i;    end
            default:     legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
// ============================================================================
// rv_multicycle_ctrl : multicycle RV32I control FSM with memory handshake,
//                      wait watchdog and retired-instruction counter
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             br_ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [15:0] c_wd_last = 16'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    op_class_t        cls_q, cls_d;
    logic [2:0]       imm_q, imm_d;
    logic [15:0]      wd_q, wd_d;
    logic             run_q, run_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    op_class_t  dec_class;
    logic [2:0] dec_imm;
    logic       dec_legal;

    logic [2:0] funct3;
    logic [4:0] rd;
    logic       br_ok;
    logic       br_take;
    logic       w_unused_instr;

    assign funct3         = instr[14:12];
    assign rd             = instr[11:7];
    assign br_ok          = branch_legal(funct3);
    assign br_take        = branch_taken(funct3, br_eq, br_lt, br_ltu);
    assign w_unused_instr = ^instr[31:15];

    rv_opcode_class u_opcode_class (
        .opcode   (instr[6:0]),
        .op_class (dec_class),
        .imm_sel  (dec_imm),
        .legal    (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        imm_d     = imm_q;
        wd_d      = wd_q;
        run_d     = 1'b1;
        cause_d   = cause_q;
        retire    = 1'b0;
        case (state_q)
            ST_FETCH, ST_MEM: begin
                // run_q gates the first cycle after reset so no request is live yet
                if (run_q) begin
                    if (mem_ready) begin
                        if (state_q == ST_FETCH) begin
                            state_d = ST_DECODE;
                        end else if (cls_q == CLS_LOAD) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_FETCH;
                            retire  = 1'b1;
                        end
                    end else if (wd_q == c_wd_last) begin
                        state_d = ST_TRAP;
                        cause_d = c_cause_timeout;
                    end else begin
                        wd_d = wd_q + 16'd1;
                    end
                end
            end
            ST_DECODE: begin
                cls_d = dec_class;
                imm_d = dec_imm;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = c_cause_illegal;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_BRANCH: begin
                        if (br_ok) begin
                            state_d = ST_FETCH;
                            retire  = 1'b1;
                        end else begin
                            state_d = ST_TRAP;
                            cause_d = c_cause_illegal;
                        end
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default: state_d = ST_TRAP;
        endcase
        if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
            wd_d = 16'd0;
        end
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_R;
            imm_q     <= c_imm_none;
            wd_q      <= 16'd0;
            run_q     <= 1'b0;
            cause_q   <= c_cause_none;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            imm_q     <= imm_d;
            wd_q      <= wd_d;
            run_q     <= run_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = c_pc_plus4;
        reg_we     = 1'b0;
        wb_sel     = c_wb_alu;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = c_alu_add;
        imm_sel    = c_imm_none;
        busy       = 1'b0;
        trap       = (state_q == ST_TRAP);
        trap_cause = cause_q;
        instret    = instret_q;

        // ALU setup stays stable from EXEC through WB so results need no holding register
        if ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)) begin
            imm_sel = imm_q;
            case (cls_q)
                CLS_R:      alu_op = c_alu_funct;
                CLS_I:      begin alu_src_b = 1'b1; alu_op = c_alu_funct; end
                CLS_BRANCH: alu_op = c_alu_sub;
                CLS_LUI:    begin alu_src_b = 1'b1; alu_op = c_alu_pass_b; end
                CLS_AUIPC,
                CLS_JAL:    begin alu_src_a = 1'b1; alu_src_b = 1'b1; end
                default:    alu_src_b = 1'b1;
            endcase
        end

        case (state_q)
            ST_FETCH: begin
                mem_req = run_q;
                ir_we   = run_q & mem_ready;
            end
            ST_DECODE: begin
                busy    = 1'b1;
                imm_sel = dec_imm;
            end
            ST_EXEC: begin
                busy = 1'b1;
                if (cls_q == CLS_BRANCH) begin
                    pc_we  = br_ok;
                    pc_src = (br_ok && br_take) ? c_pc_target : c_pc_plus4;
                end
            end
            ST_MEM: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_q == CLS_STORE);
                pc_we    = mem_ready && (cls_q == CLS_STORE);
            end
            ST_WB: begin
                busy   = 1'b1;
                pc_we  = 1'b1;
                reg_we = (rd != 5'd0);
                case (cls_q)
                    CLS_LOAD: wb_sel = c_wb_mem;
                    CLS_JAL:  begin wb_sel = c_wb_pc4; pc_src = c_pc_target; end
                    CLS_JALR: begin wb_sel = c_wb_pc4; pc_src = c_pc_jalr;   end
                    default:  wb_sel = c_wb_alu;
                endcase
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
